// File: rtl/zz_block_pingpong_ctrl.sv
// Ping-pong buffer controller: steers zig-zag coefficient writes into two RAM banks
// and streams each completed block downstream up to its last non-zero index.
module zz_block_pingpong_ctrl #(
    parameter int DW = 12
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [5:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [5:0]    max_nz_in,
    input  logic          eof_in,
    output logic          stall_out,
    output logic          ram_wr_en,
    output logic [6:0]    ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic          ram_rd_en,
    output logic [6:0]    ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_idx,
    output logic          out_last,
    output logic          out_eof,
    output logic [1:0]    err
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic          wr_bank_q, rd_bank_q;
    logic [1:0]    full_q, full_d;
    logic [6:0]    wr_cnt_q;
    logic [5:0]    nz_q [2];
    logic          eof_pend_q;
    logic [1:0]    err_q;
    logic          cmpl_q, cmpl_bank_q;
    logic [1:0]    state_q, state_d;
    logic [5:0]    rd_idx_q, lim_q;
    logic          infl_q, infl_last_q;
    logic [5:0]    infl_idx_q;
    logic [DW-1:0] fifo_data_q [2];
    logic [5:0]    fifo_idx_q [2];
    logic [1:0]    fifo_last_q;
    logic          fifo_wp_q, fifo_rp_q;
    logic [1:0]    fifo_cnt_q;

    logic       wr_acc, blk_done, pop, issue, release_bank;
    logic [2:0] occ;

    assign stall_out    = full_q[wr_bank_q];
    assign wr_acc       = wr_en && !stall_out;
    assign blk_done     = wr_acc && (wr_cnt_q == 7'd63);
    assign ram_wr_en    = wr_acc;
    assign ram_wr_addr  = {wr_bank_q, wr_addr};
    assign ram_wr_data  = wr_data;

    assign out_valid    = (fifo_cnt_q != 2'd0);
    assign out_data     = fifo_data_q[fifo_rp_q];
    assign out_idx      = fifo_idx_q[fifo_rp_q];
    assign out_last     = fifo_last_q[fifo_rp_q];
    assign pop          = out_valid && out_ready;

    // Occupancy counts the beat leaving this cycle so a full-rate stream never bubbles.
    assign occ          = {1'b0, fifo_cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign issue        = (state_q == S_STREAM) && (occ < 3'd2);
    assign ram_rd_en    = issue;
    assign ram_rd_addr  = {rd_bank_q, rd_idx_q};
    assign release_bank = (state_q == S_DRAIN) && pop && out_last;

    assign out_eof      = eof_pend_q && (full_q == 2'b00) && (state_q == S_IDLE);
    assign err          = err_q;

    always_comb begin
        full_d = full_q;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
        if (blk_done)     full_d[wr_bank_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (full_q[rd_bank_q]) state_d = S_ARM;
            S_ARM:    state_d = S_STREAM;
            S_STREAM: if (issue && (rd_idx_q == lim_q)) state_d = S_DRAIN;
            S_DRAIN:  if (release_bank) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            wr_cnt_q    <= 7'd0;
            nz_q[0]     <= 6'd0;
            nz_q[1]     <= 6'd0;
            eof_pend_q  <= 1'b0;
            err_q       <= 2'b00;
            cmpl_q      <= 1'b0;
            cmpl_bank_q <= 1'b0;
        end else begin
            // The quantizer presents max_nz one cycle after the block's final write.
            cmpl_q <= blk_done;
            if (blk_done) cmpl_bank_q <= wr_bank_q;
            if (cmpl_q) nz_q[cmpl_bank_q] <= max_nz_in;
            if (blk_done) begin
                wr_cnt_q  <= 7'd0;
                wr_bank_q <= ~wr_bank_q;
            end else if (eof_in) begin
                wr_cnt_q <= 7'd0;
            end else if (wr_acc) begin
                wr_cnt_q <= wr_cnt_q + 7'd1;
            end
            if (wr_en && stall_out) err_q[0] <= 1'b1;
            if (eof_in && !blk_done && ((wr_cnt_q != 7'd0) || wr_acc)) err_q[1] <= 1'b1;
            if (eof_in) eof_pend_q <= 1'b1;
            else if (out_eof) eof_pend_q <= 1'b0;
            full_q <= full_d;
            if (release_bank) rd_bank_q <= ~rd_bank_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rd_idx_q       <= 6'd0;
            lim_q          <= 6'd0;
            infl_q         <= 1'b0;
            infl_idx_q     <= 6'd0;
            infl_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= 6'd0;
            fifo_idx_q[1]  <= 6'd0;
            fifo_last_q    <= 2'b00;
            fifo_wp_q      <= 1'b0;
            fifo_rp_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ARM) begin
                rd_idx_q <= 6'd0;
                lim_q    <= nz_q[rd_bank_q];
            end else if (issue) begin
                rd_idx_q <= rd_idx_q + 6'd1;
            end
            infl_q <= issue;
            if (issue) begin
                infl_idx_q  <= rd_idx_q;
                infl_last_q <= (rd_idx_q == lim_q);
            end
            if (infl_q) begin
                fifo_data_q[fifo_wp_q] <= ram_rd_data;
                fifo_idx_q[fifo_wp_q]  <= infl_idx_q;
                fifo_last_q[fifo_wp_q] <= infl_last_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end
endmodule

// File: doc/zz_block_pingpong_ctrl.md
# zz_block_pingpong_ctrl

Ping-pong buffer controller between the quantization stage and the entropy coder. It accepts coefficient writes in zig-zag order, steers them into one of two 64-entry banks of an external 128x12 synchronous RAM, and records each block's last non-zero index. It then streams each completed block downstream only up to that index, and back-pressures the quantizer when both banks are occupied.

## Interface
- DW, 12, coefficient width
- clk_in  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  coefficient write strobe from quantizer
- wr_addr  in  6  zig-zag index of coefficient
- wr_data  in  DW  quantized coefficient
- max_nz_in  in  6  highest non-zero zig-zag index of current block
- eof_in  in  1  end-of-frame pulse from quantizer
- stall_out  out  1  quantizer must not assert wr_en while high
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  7  {bank, wr_addr}
- ram_wr_data  out  DW  RAM write data
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  7  {bank, index}
- ram_rd_data  in  DW  RAM read data, valid one cycle after ram_rd_en
- out_valid  out  1  downstream coefficient valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  coefficient
- out_idx  out  6  zig-zag index of out_data
- out_last  out  1  final coefficient of block (out_idx == block max_nz)
- out_eof  out  1  one-cycle pulse, frame fully drained
- err  out  2  sticky: [0] write while stalled, [1] eof with partial block

## Operation
- State: wr_bank, rd_bank (1 bit each), full[1:0], wr_cnt[6:0], nz[0..1][5:0], eof_pend.
- Write path: ram_wr_* are combinational pass-through of wr_en/wr_addr/wr_data with bank = wr_bank, gated by !stall_out.
  - Each accepted write increments wr_cnt.
  - On the 64th accepted write, set full[wr_bank], toggle wr_bank and clear wr_cnt.
  - max_nz_in is sampled into nz[completed bank] on the cycle after the 64th write.
- stall_out = full[wr_bank], registered state.
  - A wr_en while stall_out is high is dropped and sets err[0].
- Read FSM states:
  - IDLE: wait for full[rd_bank]. Load rd_idx=0 and lim=nz[rd_bank] one cycle after full rises, so the late nz sample is captured. Go to STREAM.
  - STREAM: issue reads for rd_idx=0..lim into a 2-entry output FIFO. Issue a read only when FIFO occupancy plus reads in flight is below 2. Go to DRAIN after issuing rd_idx==lim.
  - DRAIN: wait for the handshake of the out_last beat. Then clear full[rd_bank], toggle rd_bank and return to IDLE.
- lim==0 streams only the DC term, with out_last high on the first beat.
- Trailing coefficients above lim are never read.
- EOF handling:
  - eof_in with wr_cnt==0 sets eof_pend.
  - eof_in with wr_cnt!=0 sets err[1], discards the partial block (wr_cnt cleared, wr_bank unchanged) and sets eof_pend.
  - out_eof pulses when eof_pend is set, full==0 and FSM is IDLE. eof_pend clears on the same edge.
- Simultaneous events:
  - Block completion into one bank and drain-free of the other on the same edge both take effect.
  - If the freed bank equals wr_bank, stall_out drops on the next cycle.
- err clears only on rst.

## Timing
- Reset: all outputs 0; stall_out=0; err=0. Internal state: wr_bank=rd_bank=0, full=0, FIFO empty, FSM IDLE.
- Reset mid-block discards all buffered data; no out_eof is generated.
- Write-to-RAM latency is 0 (combinational).
- First out_valid appears 4 cycles after the edge on which the 64th write is accepted: full set, nz sampled/lim loaded, read issued, data captured into FIFO.
- With out_ready held high, throughput is one coefficient per cycle after the first beat.
- out_valid/out_data/out_idx/out_last hold stable while out_valid && !out_ready.
- stall_out rises the cycle after completion of a block when the other bank is still full.

## Test plan
- Single block, 64 writes of wr_data=idx, max_nz_in=10 -> exactly 11 beats, out_idx 0..10, out_data 0..10. out_last on idx 10, then out_eof after eof_in.
- max_nz_in=0 -> one beat, idx 0, out_last=1. Bank freed; stall_out never asserted.
- Three back-to-back blocks with out_ready=0 -> stall_out=1 after block 2. Release out_ready -> stall_out falls after block 1 drains, and block 3 data lands in bank 0.
- wr_en while stall_out=1 -> RAM write suppressed, err[0]=1. Data of queued blocks unchanged.
- eof_in after 20 writes -> err[1]=1, no output for the partial block. out_eof pulses once the earlier full blocks drain.
- out_ready toggling every cycle during a 64-beat block (max_nz=63) -> all 64 beats in order with no duplicates, data stable while stalled.
